// File: rtl/rv32i_types.sv
// Shared RV32 decode types: reservation-station indices, stage uop and op encodings.
// Imported by the dispatch stage and its operand selectors.
package rv32i_types;

  localparam int RVS_ALU = 0;
  localparam int RVS_MDU = 1;
  localparam int RVS_LSU = 2;
  localparam int RVS_JMP = 3;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  typedef enum logic {
    op_b_reg = 1'b0,
    op_b_imm = 1'b1
  } op_b_t;

  localparam logic [3:0] alu_op_add = 4'b0000;
  localparam logic [3:0] alu_op_sub = 4'b1000;
  localparam logic [3:0] alu_op_sra = 4'b1101;
  localparam logic [3:0] jmp_op_jal  = 4'b1000;
  localparam logic [3:0] jmp_op_jalr = 4'b1001;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  cls;
    logic [3:0]  opc;
    logic        use1;
    op_b_t       op_b;
    logic [31:0] imm1;
    logic [31:0] imm2;
    logic [11:0] offset;
    logic        has_rd;
    logic        illegal;
  } uop_t;

endpackage

// File: rtl/disp_src_sel.sv
// Per-operand source resolution: immediate, x0, RAT value, CDB bypass or tag.
// Purely combinational; the issue-cycle RAT/CDB values are used directly.
module disp_src_sel
  import rv32i_types::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             use_reg,
  input  logic [4:0]       addr,
  input  logic [31:0]      imm,
  input  logic             rat_valid,
  input  logic [TAG_W-1:0] rat_tag,
  input  logic [31:0]      rat_rdata,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_rob_id,
  input  logic [31:0]      cdb_rdata,
  output logic             vld,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      data
);

  always_comb begin
    vld  = 1'b0;
    tag  = '0;
    data = '0;
    if (!use_reg) begin
      vld  = 1'b1;
      data = imm;
    end else if (addr == 5'd0) begin
      vld  = 1'b1;
    end else if (rat_valid) begin
      vld  = 1'b1;
      data = rat_rdata;
    end else if (cdb_valid && cdb_rob_id == rat_tag) begin
      vld  = 1'b1;
      data = cdb_rdata;
    end else begin
      tag  = rat_tag;
    end
  end

endmodule

// File: rtl/disp_stage.sv
// Decode/dispatch stage: one registered micro-op, renamed and steered
// to the ALU/MDU/LSU/JMP reservation stations with ROB allocation.
module disp_stage
  import rv32i_types::*;
#(
  parameter int TAG_W  = 4,
  parameter bit MDU_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iq_valid,
  input  logic [63:0]      iq_rdata,
  output logic             iq_deq,
  input  logic             flush,
  input  logic             rob_rdy,
  input  logic [TAG_W-1:0] rob_inst_id,
  output logic             rob_issue,
  output logic [31:0]      rob_inst,
  output logic [31:0]      rob_pc,
  output logic             rob_illegal,
  output logic [4:0]       rat_rs1_addr,
  output logic [4:0]       rat_rs2_addr,
  input  logic             rat_rs1_valid,
  input  logic [TAG_W-1:0] rat_rs1_tag,
  input  logic [31:0]      rat_rs1_rdata,
  input  logic             rat_rs2_valid,
  input  logic [TAG_W-1:0] rat_rs2_tag,
  input  logic [31:0]      rat_rs2_rdata,
  output logic             rat_rd_wr,
  output logic [4:0]       rat_rd_addr,
  output logic [TAG_W-1:0] rat_rob_id,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_rob_id,
  input  logic [31:0]      cdb_rdata,
  output logic [3:0]       rvs_req,
  input  logic [3:0]       rvs_rdy,
  output logic [3:0]       rvs_opc,
  output logic             rvs_src1_vld,
  output logic             rvs_src2_vld,
  output logic [TAG_W-1:0] rvs_src1_tag,
  output logic [TAG_W-1:0] rvs_src2_tag,
  output logic [31:0]      rvs_src1_wdata,
  output logic [31:0]      rvs_src2_wdata,
  output logic [11:0]      rvs_offset,
  output logic [TAG_W-1:0] rvs_inst_id,
  output logic [CNT_W-1:0] stat_disp,
  output logic [CNT_W-1:0] stat_stall
);

  uop_t uop;
  uop_t dec;

  logic [31:0] ins;
  logic [6:0]  opc7;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        fire;
  logic        go;
  logic        s1_vld;
  logic        s2_vld;

  assign ins   = iq_rdata[31:0];
  assign opc7  = ins[6:0];
  assign f3    = ins[14:12];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{12{ins[31]}}, ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    dec.vld    = 1'b1;
    dec.pc     = iq_rdata[63:32];
    dec.inst   = ins;
    dec.cls    = 2'(RVS_ALU);
    dec.use1   = 1'b1;
    dec.op_b   = op_b_reg;
    dec.has_rd = 1'b1;
    unique case (1'b1)
      (opc7 == OPC_LUI): begin
        dec.use1 = 1'b0;
        dec.op_b = op_b_imm;
        dec.imm2 = imm_u;
        dec.opc  = alu_op_add;
      end
      (opc7 == OPC_AUIPC): begin
        dec.use1 = 1'b0;
        dec.imm1 = iq_rdata[63:32];
        dec.op_b = op_b_imm;
        dec.imm2 = imm_u;
        dec.opc  = alu_op_add;
      end
      (opc7 == OPC_OPIMM): begin
        dec.op_b   = op_b_imm;
        dec.imm2   = imm_i;
        dec.offset = ins[31:20];
        dec.opc    = {(f3 == 3'b101) & ins[30], f3};
      end
      (opc7 == OPC_OP): begin
        if (ins[31:25] == 7'b0000001) begin
          if (MDU_EN) begin
            dec.cls = 2'(RVS_MDU);
            dec.opc = {1'b0, f3};
          end else begin
            dec.illegal = 1'b1;
            dec.has_rd  = 1'b0;
          end
        end else begin
          dec.opc = {ins[30], f3};
        end
      end
      (opc7 == OPC_LOAD): begin
        dec.cls    = 2'(RVS_LSU);
        dec.op_b   = op_b_imm;
        dec.imm2   = imm_i;
        dec.offset = ins[31:20];
        dec.opc    = {1'b0, f3};
      end
      (opc7 == OPC_STORE): begin
        dec.cls    = 2'(RVS_LSU);
        dec.offset = {ins[31:25], ins[11:7]};
        dec.opc    = {1'b1, f3};
        dec.has_rd = 1'b0;
      end
      (opc7 == OPC_JAL): begin
        dec.cls  = 2'(RVS_JMP);
        dec.use1 = 1'b0;
        dec.imm1 = iq_rdata[63:32];
        dec.op_b = op_b_imm;
        dec.imm2 = imm_j;
        dec.opc  = jmp_op_jal;
      end
      (opc7 == OPC_JALR): begin
        dec.cls    = 2'(RVS_JMP);
        dec.op_b   = op_b_imm;
        dec.imm2   = iq_rdata[63:32];
        dec.offset = ins[31:20];
        dec.opc    = jmp_op_jalr;
      end
      (opc7 == OPC_BR): begin
        dec.cls    = 2'(RVS_JMP);
        dec.offset = {ins[31], ins[7], ins[30:25], ins[11:8]};
        dec.opc    = {1'b0, f3};
        dec.has_rd = 1'b0;
      end
      default: begin
        dec.illegal = 1'b1;
        dec.has_rd  = 1'b0;
      end
    endcase
  end

  // go: stage may hand off this cycle, pending only the RS ready
  assign go     = uop.vld & ~flush & rob_rdy;
  assign fire   = go & (uop.illegal | rvs_rdy[uop.cls]);
  assign iq_deq = iq_valid & ~flush & (~uop.vld | fire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uop <= '0;
    end else if (iq_deq) begin
      uop <= dec;
    end else if (fire || flush) begin
      uop.vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_disp  <= '0;
      stat_stall <= '0;
    end else begin
      if (fire)
        stat_disp <= stat_disp + CNT_W'(1);
      if (uop.vld && !flush && !fire)
        stat_stall <= stat_stall + CNT_W'(1);
    end
  end

  disp_src_sel #(.TAG_W(TAG_W)) u_src1 (
    .use_reg    (uop.use1),
    .addr       (uop.inst[19:15]),
    .imm        (uop.imm1),
    .rat_valid  (rat_rs1_valid),
    .rat_tag    (rat_rs1_tag),
    .rat_rdata  (rat_rs1_rdata),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_rdata  (cdb_rdata),
    .vld        (s1_vld),
    .tag        (rvs_src1_tag),
    .data       (rvs_src1_wdata)
  );

  disp_src_sel #(.TAG_W(TAG_W)) u_src2 (
    .use_reg    (uop.op_b == op_b_reg),
    .addr       (uop.inst[24:20]),
    .imm        (uop.imm2),
    .rat_valid  (rat_rs2_valid),
    .rat_tag    (rat_rs2_tag),
    .rat_rdata  (rat_rs2_rdata),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_rdata  (cdb_rdata),
    .vld        (s2_vld),
    .tag        (rvs_src2_tag),
    .data       (rvs_src2_wdata)
  );

  assign rvs_src1_vld = uop.vld & s1_vld;
  assign rvs_src2_vld = uop.vld & s2_vld;
  assign rvs_req      = (go & ~uop.illegal) ? (4'b0001 << uop.cls) : 4'b0000;
  assign rvs_opc      = uop.opc;
  assign rvs_offset   = uop.offset;
  assign rvs_inst_id  = uop.vld ? rob_inst_id : '0;
  assign rob_issue    = fire;
  assign rob_inst     = uop.inst;
  assign rob_pc       = uop.pc;
  assign rob_illegal  = uop.illegal;
  assign rat_rs1_addr = uop.inst[19:15];
  assign rat_rs2_addr = uop.inst[24:20];
  assign rat_rd_addr  = uop.inst[11:7];
  assign rat_rob_id   = uop.vld ? rob_inst_id : '0;
  assign rat_rd_wr    = fire & ~uop.illegal & uop.has_rd
                      & (uop.inst[11:7] != 5'd0);

endmodule

// File: tb/tb_disp_stage.sv
// Bench for disp_stage: decode table, hand-written corner sequences and
// a randomized run against a behavioural model of the stage.
module tb_disp_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iq_valid, flush, rob_rdy, cdb_valid;
  logic [63:0] iq_rdata;
  logic [3:0]  rob_inst_id, cdb_rob_id, rvs_rdy;
  logic        rat_rs1_valid, rat_rs2_valid;
  logic [3:0]  rat_rs1_tag, rat_rs2_tag;
  logic [31:0] rat_rs1_rdata, rat_rs2_rdata, cdb_rdata;

  logic        iq_deq, rob_issue, rob_illegal, rat_rd_wr;
  logic        rvs_src1_vld, rvs_src2_vld;
  logic [31:0] rob_inst, rob_pc, rvs_src1_wdata, rvs_src2_wdata;
  logic [4:0]  rat_rs1_addr, rat_rs2_addr, rat_rd_addr;
  logic [3:0]  rat_rob_id, rvs_req, rvs_opc, rvs_src1_tag;
  logic [3:0]  rvs_src2_tag, rvs_inst_id;
  logic [11:0] rvs_offset;
  logic [31:0] stat_disp, stat_stall;

  logic        m_iq_deq, m_rob_issue, m_rob_illegal, m_rat_rd_wr;
  logic        m_src1_vld, m_src2_vld;
  logic [31:0] m_rob_inst, m_rob_pc, m_src1_wdata, m_src2_wdata;
  logic [4:0]  m_rs1_addr, m_rs2_addr, m_rd_addr;
  logic [3:0]  m_rob_id, m_rvs_req, m_rvs_opc, m_src1_tag;
  logic [3:0]  m_src2_tag, m_inst_id;
  logic [11:0] m_offset;
  logic [31:0] m_stat_disp, m_stat_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_stage #(.TAG_W(4), .MDU_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .iq_valid(iq_valid), .iq_rdata(iq_rdata), .iq_deq(iq_deq),
    .flush(flush), .rob_rdy(rob_rdy), .rob_inst_id(rob_inst_id),
    .rob_issue(rob_issue), .rob_inst(rob_inst), .rob_pc(rob_pc),
    .rob_illegal(rob_illegal),
    .rat_rs1_addr(rat_rs1_addr), .rat_rs2_addr(rat_rs2_addr),
    .rat_rs1_valid(rat_rs1_valid), .rat_rs1_tag(rat_rs1_tag),
    .rat_rs1_rdata(rat_rs1_rdata),
    .rat_rs2_valid(rat_rs2_valid), .rat_rs2_tag(rat_rs2_tag),
    .rat_rs2_rdata(rat_rs2_rdata),
    .rat_rd_wr(rat_rd_wr), .rat_rd_addr(rat_rd_addr),
    .rat_rob_id(rat_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_rdata(cdb_rdata),
    .rvs_req(rvs_req), .rvs_rdy(rvs_rdy), .rvs_opc(rvs_opc),
    .rvs_src1_vld(rvs_src1_vld), .rvs_src2_vld(rvs_src2_vld),
    .rvs_src1_tag(rvs_src1_tag), .rvs_src2_tag(rvs_src2_tag),
    .rvs_src1_wdata(rvs_src1_wdata), .rvs_src2_wdata(rvs_src2_wdata),
    .rvs_offset(rvs_offset), .rvs_inst_id(rvs_inst_id),
    .stat_disp(stat_disp), .stat_stall(stat_stall)
  );

  disp_stage #(.TAG_W(4), .MDU_EN(1'b0), .CNT_W(32)) dut_nom (
    .clk(clk), .rst(rst),
    .iq_valid(iq_valid), .iq_rdata(iq_rdata), .iq_deq(m_iq_deq),
    .flush(flush), .rob_rdy(rob_rdy), .rob_inst_id(rob_inst_id),
    .rob_issue(m_rob_issue), .rob_inst(m_rob_inst), .rob_pc(m_rob_pc),
    .rob_illegal(m_rob_illegal),
    .rat_rs1_addr(m_rs1_addr), .rat_rs2_addr(m_rs2_addr),
    .rat_rs1_valid(rat_rs1_valid), .rat_rs1_tag(rat_rs1_tag),
    .rat_rs1_rdata(rat_rs1_rdata),
    .rat_rs2_valid(rat_rs2_valid), .rat_rs2_tag(rat_rs2_tag),
    .rat_rs2_rdata(rat_rs2_rdata),
    .rat_rd_wr(m_rat_rd_wr), .rat_rd_addr(m_rd_addr),
    .rat_rob_id(m_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_rdata(cdb_rdata),
    .rvs_req(m_rvs_req), .rvs_rdy(rvs_rdy), .rvs_opc(m_rvs_opc),
    .rvs_src1_vld(m_src1_vld), .rvs_src2_vld(m_src2_vld),
    .rvs_src1_tag(m_src1_tag), .rvs_src2_tag(m_src2_tag),
    .rvs_src1_wdata(m_src1_wdata), .rvs_src2_wdata(m_src2_wdata),
    .rvs_offset(m_offset), .rvs_inst_id(m_inst_id),
    .stat_disp(m_stat_disp), .stat_stall(m_stat_stall)
  );

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    iq_valid = 0; iq_rdata = '0; flush = 0; rob_rdy = 1;
    rob_inst_id = 4'd3; rvs_rdy = 4'hF;
    rat_rs1_valid = 1; rat_rs1_tag = 0; rat_rs1_rdata = 32'h111;
    rat_rs2_valid = 1; rat_rs2_tag = 0; rat_rs2_rdata = 32'h222;
    cdb_valid = 0; cdb_rob_id = 0; cdb_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    nxt(); nxt();
    rst = 1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  req;
    logic        ill;
    logic [3:0]  opc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [11:0] off;
    logic        wr;
  } vec_t;

  vec_t tbl[12];

  // Behavioural reference: decode rules from the ISA field layout
  typedef struct {
    logic        ill;
    int          cls;
    logic [3:0]  opc;
    logic        u1, u2;
    logic [31:0] d1, d2;
    logic [11:0] off;
    logic        wr;
  } ref_t;

  function automatic ref_t ref_dec(logic [31:0] i, logic [31:0] pc);
    ref_t r;
    logic [31:0] ii;
    logic [12:0] b;
    r = '{ill: 0, cls: 0, opc: 0, u1: 1, u2: 1, d1: 0, d2: 0,
          off: 0, wr: 1};
    ii = 32'($signed(i[31:20]));
    b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    case (i[6:0])
      7'h37: begin r.u1 = 0; r.u2 = 0; r.d2 = {i[31:12], 12'h0}; end
      7'h17: begin
        r.u1 = 0; r.u2 = 0; r.d1 = pc; r.d2 = {i[31:12], 12'h0};
      end
      7'h13: begin
        r.u2 = 0; r.d2 = ii; r.off = i[31:20];
        r.opc = (i[14:12] == 5) ? {i[30], i[14:12]} : {1'b0, i[14:12]};
      end
      7'h33: begin
        if (i[31:25] == 7'd1) begin
          r.cls = 1; r.opc = {1'b0, i[14:12]};
        end else r.opc = {i[30], i[14:12]};
      end
      7'h03: begin
        r.cls = 2; r.u2 = 0; r.d2 = ii; r.off = i[31:20];
        r.opc = {1'b0, i[14:12]};
      end
      7'h23: begin
        r.cls = 2; r.opc = {1'b1, i[14:12]}; r.wr = 0;
        r.off = {i[31:25], i[11:7]};
      end
      7'h6F: begin
        r.cls = 3; r.opc = 8; r.u1 = 0; r.u2 = 0; r.d1 = pc;
        r.d2 = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h67: begin
        r.cls = 3; r.opc = 9; r.u2 = 0; r.d2 = pc; r.off = i[31:20];
      end
      7'h63: begin
        r.cls = 3; r.opc = {1'b0, i[14:12]}; r.off = b[12:1]; r.wr = 0;
      end
      default: begin r.ill = 1; r.wr = 0; end
    endcase
    if (i[11:7] == 0) r.wr = 0;
    return r;
  endfunction

  task automatic chk_src(string nm, logic u, logic [4:0] a,
                         logic [31:0] imm, logic rv, logic [3:0] rt,
                         logic [31:0] rd, logic av, logic [3:0] at,
                         logic [31:0] ad);
    logic ev;
    logic [31:0] ed;
    ev = 1; ed = 0;
    if (!u) ed = imm;
    else if (a == 0) ed = 0;
    else if (rv) ed = rd;
    else if (cdb_valid && cdb_rob_id == rt) ed = cdb_rdata;
    else ev = 0;
    chk({nm, "_vld"}, 64'(av), 64'(ev));
    if (ev) chk({nm, "_data"}, 64'(ad), 64'(ed));
    else chk({nm, "_tag"}, 64'(at), 64'(rt));
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 9))
      0: i[6:0] = 7'h37;
      1: i[6:0] = 7'h17;
      2: i[6:0] = 7'h13;
      3: begin
        i[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0: i[31:25] = 7'h00;
          1: i[31:25] = 7'h20;
          default: i[31:25] = 7'h01;
        endcase
      end
      4: i[6:0] = 7'h03;
      5: i[6:0] = 7'h23;
      6: i[6:0] = 7'h6F;
      7: i[6:0] = 7'h67;
      8: i[6:0] = 7'h63;
      default: i[6:0] = 7'h7F;
    endcase
    if ($urandom_range(0, 3) == 0) i[19:15] = 0;
    if ($urandom_range(0, 3) == 0) i[24:20] = 0;
    if ($urandom_range(0, 5) == 0) i[11:7] = 0;
    return i;
  endfunction

  logic [31:0] ops[4];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          m_vld;
    logic [31:0] m_pc, m_inst;
    int unsigned n_disp, n_stall;
    int          idx;
    logic        deq;
    ref_t        r;
    logic        e_fire, e_deq;

    tbl[0]  = '{32'h00500093, 4'b0001, 0, 4'h0, 32'h0, 32'h5, 12'h005, 1};
    tbl[1]  = '{32'h402081B3, 4'b0001, 0, 4'h8, 32'h111, 32'h222, 12'h0, 1};
    tbl[2]  = '{32'h123452B7, 4'b0001, 0, 4'h0, 32'h0, 32'h12345000, 12'h0, 1};
    tbl[3]  = '{32'h00001317, 4'b0001, 0, 4'h0, 32'h100, 32'h1000, 12'h0, 1};
    tbl[4]  = '{32'h022083B3, 4'b0010, 0, 4'h0, 32'h111, 32'h222, 12'h0, 1};
    tbl[5]  = '{32'hFFC0A403, 4'b0100, 0, 4'h2, 32'h111, 32'hFFFFFFFC, 12'hFFC, 1};
    tbl[6]  = '{32'h0020A423, 4'b0100, 0, 4'hA, 32'h111, 32'h222, 12'h008, 0};
    tbl[7]  = '{32'h010000EF, 4'b1000, 0, 4'h8, 32'h100, 32'h10, 12'h0, 1};
    tbl[8]  = '{32'h00008067, 4'b1000, 0, 4'h9, 32'h111, 32'h100, 12'h0, 0};
    tbl[9]  = '{32'hFE208CE3, 4'b1000, 0, 4'h0, 32'h111, 32'h222, 12'hFFC, 0};
    tbl[10] = '{32'h4030D213, 4'b0001, 0, 4'hD, 32'h111, 32'h403, 12'h403, 1};
    tbl[11] = '{32'h0000007F, 4'b0000, 1, 4'h0, 32'h0, 32'h0, 12'h0, 0};

    idle();
    #12;
    chk("rst_req", 64'(rvs_req), 0);
    chk("rst_issue", 64'(rob_issue), 0);
    chk("rst_disp", 64'(stat_disp), 0);
    chk("rst_stall", 64'(stat_stall), 0);
    chk("rst_inst", 64'(rob_inst), 0);
    chk("rst_src1_vld", 64'(rvs_src1_vld), 0);
    chk("rst_rs1_addr", 64'(rat_rs1_addr), 0);
    chk("rst_wr", 64'(rat_rd_wr), 0);
    @(posedge clk); #1;
    rst = 1;

    // decode table
    for (int k = 0; k < 12; k++) begin
      iq_valid = 1;
      iq_rdata = {32'h100, tbl[k].inst};
      smp();
      chk($sformatf("t%0d_deq", k), 64'(iq_deq), 1);
      chk($sformatf("t%0d_early_req", k), 64'(rvs_req), 0);
      nxt();
      iq_valid = 0;
      smp();
      chk($sformatf("t%0d_req", k), 64'(rvs_req), 64'(tbl[k].req));
      chk($sformatf("t%0d_issue", k), 64'(rob_issue), 1);
      chk($sformatf("t%0d_ill", k), 64'(rob_illegal), 64'(tbl[k].ill));
      chk($sformatf("t%0d_wr", k), 64'(rat_rd_wr), 64'(tbl[k].wr));
      chk($sformatf("t%0d_pc", k), 64'(rob_pc), 32'h100);
      if (!tbl[k].ill) begin
        chk($sformatf("t%0d_opc", k), 64'(rvs_opc), 64'(tbl[k].opc));
        chk($sformatf("t%0d_s1", k), 64'(rvs_src1_wdata), 64'(tbl[k].s1));
        chk($sformatf("t%0d_s2", k), 64'(rvs_src2_wdata), 64'(tbl[k].s2));
        chk($sformatf("t%0d_v", k), 64'({rvs_src1_vld, rvs_src2_vld}), 3);
        chk($sformatf("t%0d_off", k), 64'(rvs_offset), 64'(tbl[k].off));
        chk($sformatf("t%0d_rd", k), 64'(rat_rd_addr),
            64'(tbl[k].inst[11:7]));
        chk($sformatf("t%0d_id", k), 64'(rvs_inst_id), 3);
      end
      nxt();
    end
    smp();
    chk("tbl_disp", 64'(stat_disp), 12);

    // stall then stream four ALU ops
    do_reset(); idle();
    ops[0] = 32'h00100093; ops[1] = 32'h00200113;
    ops[2] = 32'h00300193; ops[3] = 32'h00400213;
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      iq_valid = (idx < 4);
      iq_rdata = {32'h200, ops[idx < 4 ? idx : 0]};
      rvs_rdy  = (c >= 1 && c <= 3) ? 4'b1110 : 4'hF;
      smp();
      deq = iq_deq;
      if (c >= 1 && c <= 3) begin
        chk($sformatf("stl%0d_req", c), 64'(rvs_req), 1);
        chk($sformatf("stl%0d_issue", c), 64'(rob_issue), 0);
        chk($sformatf("stl%0d_deq", c), 64'(iq_deq), 0);
        chk($sformatf("stl%0d_inst", c), 64'(rob_inst), 64'(ops[0]));
      end
      if (c >= 4 && c <= 7) begin
        chk($sformatf("str%0d_issue", c), 64'(rob_issue), 1);
        chk($sformatf("str%0d_inst", c), 64'(rob_inst), 64'(ops[c-4]));
      end
      if (c == 8) begin
        chk("str_stall", 64'(stat_stall), 3);
        chk("str_disp", 64'(stat_disp), 4);
      end
      nxt();
      if (deq) idx++;
    end

    // CDB bypass in the issue cycle
    do_reset(); idle();
    rat_rs1_valid = 0; rat_rs1_tag = 5;
    rat_rs2_valid = 0; rat_rs2_tag = 7;
    cdb_valid = 1; cdb_rob_id = 5; cdb_rdata = 32'hDEAD;
    iq_valid = 1; iq_rdata = {32'h300, 32'h002081B3};
    nxt();
    iq_valid = 0;
    smp();
    chk("cdb_s1_vld", 64'(rvs_src1_vld), 1);
    chk("cdb_s1_data", 64'(rvs_src1_wdata), 32'hDEAD);
    chk("cdb_s2_vld", 64'(rvs_src2_vld), 0);
    chk("cdb_s2_tag", 64'(rvs_src2_tag), 7);
    chk("cdb_req", 64'(rvs_req), 1);
    nxt();

    // M-op without MDU
    do_reset(); idle();
    iq_valid = 1; iq_rdata = {32'h400, 32'h022083B3};
    nxt();
    iq_valid = 0;
    smp();
    chk("nom_req", 64'(m_rvs_req), 0);
    chk("nom_issue", 64'(m_rob_issue), 1);
    chk("nom_ill", 64'(m_rob_illegal), 1);
    chk("nom_wr", 64'(m_rat_rd_wr), 0);
    chk("mdu_req", 64'(rvs_req), 4'b0010);
    nxt();

    // flush while held
    do_reset(); idle();
    rvs_rdy = 0;
    iq_valid = 1; iq_rdata = {32'h500, 32'h00100093};
    nxt();
    iq_rdata = {32'h504, 32'h00200113};
    flush = 1;
    smp();
    chk("fl_deq", 64'(iq_deq), 0);
    chk("fl_issue", 64'(rob_issue), 0);
    chk("fl_req", 64'(rvs_req), 0);
    nxt();
    flush = 0;
    smp();
    chk("fl_empty_req", 64'(rvs_req), 0);
    chk("fl_next_deq", 64'(iq_deq), 1);
    chk("fl_stall", 64'(stat_stall), 0);
    nxt();
    iq_valid = 0; rvs_rdy = 4'hF;
    smp();
    chk("fl_new_inst", 64'(rob_inst), 32'h00200113);
    chk("fl_new_issue", 64'(rob_issue), 1);
    nxt();

    // store under ROB back-pressure
    do_reset(); idle();
    rob_rdy = 0;
    iq_valid = 1; iq_rdata = {32'h600, 32'h0020A423};
    nxt();
    iq_valid = 0;
    for (int c = 0; c < 2; c++) begin
      smp();
      chk($sformatf("st%0d_req", c), 64'(rvs_req), 0);
      chk($sformatf("st%0d_issue", c), 64'(rob_issue), 0);
      nxt();
    end
    rob_rdy = 1;
    smp();
    chk("st_req", 64'(rvs_req), 4'b0100);
    chk("st_opc3", 64'(rvs_opc[3]), 1);
    chk("st_off", 64'(rvs_offset), 8);
    chk("st_wr", 64'(rat_rd_wr), 0);
    chk("st_stall", 64'(stat_stall), 2);
    nxt();

    // asynchronous reset while FULL
    do_reset(); idle();
    rvs_rdy = 0;
    iq_valid = 1; iq_rdata = {32'h700, 32'h00100093};
    nxt();
    iq_valid = 0;
    smp();
    chk("ar_req_before", 64'(rvs_req), 1);
    rst = 0;
    #1;
    chk("ar_req_now", 64'(rvs_req), 0);
    #1;
    rst = 1;
    rvs_rdy = 4'hF;
    nxt();
    smp();
    chk("ar_issue_after", 64'(rob_issue), 0);
    chk("ar_disp_after", 64'(stat_disp), 0);
    nxt();

    // randomized run against the model
    do_reset(); idle();
    m_vld = 0; m_pc = 0; m_inst = 0; n_disp = 0; n_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      iq_valid = ($urandom_range(0, 9) < 7);
      iq_rdata = {32'($urandom), rnd_inst()};
      flush = ($urandom_range(0, 19) == 0);
      rob_rdy = ($urandom_range(0, 4) != 0);
      rob_inst_id = 4'($urandom);
      rvs_rdy = 4'($urandom) | 4'($urandom);
      rat_rs1_valid = $urandom_range(0, 1); rat_rs1_tag = 4'($urandom);
      rat_rs2_valid = $urandom_range(0, 1); rat_rs2_tag = 4'($urandom);
      rat_rs1_rdata = $urandom; rat_rs2_rdata = $urandom;
      cdb_valid = $urandom_range(0, 1); cdb_rdata = $urandom;
      case ($urandom_range(0, 2))
        0: cdb_rob_id = rat_rs1_tag;
        1: cdb_rob_id = rat_rs2_tag;
        default: cdb_rob_id = 4'($urandom);
      endcase
      smp();
      r = ref_dec(m_inst, m_pc);
      e_fire = m_vld && !flush && rob_rdy && (r.ill || rvs_rdy[r.cls]);
      e_deq = iq_valid && !flush && (!m_vld || e_fire);
      chk("r_deq", 64'(iq_deq), 64'(e_deq));
      chk("r_issue", 64'(rob_issue), 64'(e_fire));
      chk("r_req", 64'(rvs_req),
          (m_vld && !flush && rob_rdy && !r.ill) ? 64'(4'b1 << r.cls) : 0);
      chk("r_wr", 64'(rat_rd_wr), 64'(e_fire && r.wr));
      chk("r_disp", 64'(stat_disp), 64'(n_disp));
      chk("r_stall", 64'(stat_stall), 64'(n_stall));
      if (m_vld) begin
        chk("r_inst", 64'(rob_inst), 64'(m_inst));
        chk("r_pc", 64'(rob_pc), 64'(m_pc));
        chk("r_ill", 64'(rob_illegal), 64'(r.ill));
        chk("r_rd", 64'(rat_rd_addr), 64'(m_inst[11:7]));
        chk("r_robid", 64'(rat_rob_id), 64'(rob_inst_id));
        if (!r.ill) begin
          chk("r_opc", 64'(rvs_opc), 64'(r.opc));
          chk("r_off", 64'(rvs_offset), 64'(r.off));
          chk_src("r_s1", r.u1, m_inst[19:15], r.d1, rat_rs1_valid,
                  rat_rs1_tag, rat_rs1_rdata, rvs_src1_vld,
                  rvs_src1_tag, rvs_src1_wdata);
          chk_src("r_s2", r.u2, m_inst[24:20], r.d2, rat_rs2_valid,
                  rat_rs2_tag, rat_rs2_rdata, rvs_src2_vld,
                  rvs_src2_tag, rvs_src2_wdata);
        end
      end
      if (e_fire) n_disp++;
      if (m_vld && !flush && !e_fire) n_stall++;
      if (e_deq) begin
        m_vld = 1; m_inst = iq_rdata[31:0]; m_pc = iq_rdata[63:32];
      end else if (e_fire || flush) begin
        m_vld = 0;
      end
      nxt();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_stage.md
# disp_stage

Parametrised decode/dispatch stage between the instruction queue and the four reservation stations (ALU, MDU, LSU, JMP). It registers one decoded micro-op per cycle with a valid/ready pipeline handshake, reads operand state from the RAT/ROB, snoops the CDB for same-cycle wakeup, allocates a ROB entry, and renames rd. It adds flush, ROB-full back-pressure, x0 handling, illegal-instruction marking, optional M-extension and performance counters.

## Interface
- TAG_W, 4: ROB id / operand tag width
- MDU_EN, 1: 1 = decode M-extension ops to the MDU; 0 = mark them illegal
- CNT_W, 32: width of the performance counters
- clk in 1: clock
- rst in 1: asynchronous, active-low reset (asserted at 0)
- iq_valid in 1; iq_rdata in 64 {pc[31:0], inst[31:0]}; iq_deq out 1: instruction-queue pop
- flush in 1: squash the held micro-op; takes priority over everything
- rob_rdy in 1: ROB has a free entry; rob_inst_id in TAG_W: id of that entry
- rob_issue out 1; rob_inst out 32; rob_pc out 32; rob_illegal out 1
- rat_rs1_addr, rat_rs2_addr out 5; rat_rsN_valid in 1; rat_rsN_tag in TAG_W; rat_rsN_rdata in 32 (N=1,2)
- rat_rd_wr out 1; rat_rd_addr out 5; rat_rob_id out TAG_W
- cdb_valid in 1; cdb_rob_id in TAG_W; cdb_rdata in 32
- rvs_req out 4 (one-hot, index per package constants); rvs_rdy in 4
- rvs_opc out 4; rvs_src1_vld/rvs_src2_vld out 1; rvs_src1_tag/rvs_src2_tag out TAG_W; rvs_src1_wdata/rvs_src2_wdata out 32; rvs_offset out 12; rvs_inst_id out TAG_W (payload is shared by all channels)
- stat_disp out CNT_W: micro-ops issued; stat_stall out CNT_W: cycles with a valid micro-op that is not issued

## Operation
- Stage register holds {vld, pc, inst, decoded class, opc, immediates, illegal}. There are two states: EMPTY (vld=0) and FULL (vld=1).
- fire = vld & ~flush & rob_rdy & (illegal | rvs_rdy[cls]).
- iq_deq = iq_valid & ~flush & (~vld | fire). On iq_deq the stage loads the new instruction. Otherwise, fire or flush clears vld.
- Decode classes, opc and immediates use the existing encodings: lui/auipc/imm/reg → ALU; funct7=01 reg → MDU; load/store → LSU (opc[3]=store); jal/jalr/br → JMP.
- Illegal: an unknown opcode, or an M-op when MDU_EN=0. An illegal op asserts no rvs_req. It issues to the ROB with rob_illegal=1.
- rvs_req[cls] = vld & ~flush & rob_rdy & ~illegal. rob_issue = fire.
- Source resolution per operand, in priority order:
  - The operand is unused (immediate form): vld=1, data = imm/pc as decoded.
  - Register addr = 0: vld=1, data 0.
  - rat_valid: use the RAT data.
  - cdb_valid & cdb_rob_id == rat_tag: vld=1, data = cdb_rdata.
  - Otherwise: vld=0, tag = rat_tag.
- rat_rd_wr = fire & ~illegal & rd≠0 & opcode ∉ {store, br}. rat_rd_addr = rd; rat_rob_id = rob_inst_id. rvs_inst_id = rob_inst_id.
- Counters: stat_disp increments on fire. stat_stall increments when vld & ~flush & ~fire. Both wrap modulo 2^CNT_W.

## Timing
- Reset: vld=0 and both counters are 0. All outputs are 0, except rat_rsN_addr, which are 0 because the stage register is cleared.
- Latency: iq_deq at cycle t → rvs_req/rob_issue at t+1 at the earliest. Sustained throughput is 1 op/cycle while the consumer is ready.
- Back-to-back: in the FULL state, fire and iq_deq happen in the same cycle. The next op is held at t+1 with no bubble.
- Stall: while rob_rdy=0 or rvs_rdy[cls]=0, the payload stays stable and req stays asserted (except when rob_rdy=0, which drops req). iq_deq=0 when FULL.
- Flush in cycle t: no issue, no dequeue, no counter change. The stage is EMPTY at t+1.
- Asynchronous reset asserted mid-operation: vld clears immediately. No issue follows after release until a new dequeue.
- RAT and CDB inputs are sampled combinationally in the issue cycle. There is no registered wakeup.

## Structure
- Shared package (rv32i_types) holds:
  - the RVS index constants RVS_ALU=0, RVS_MDU=1, RVS_LSU=2, RVS_JMP=3
  - the uop_t struct (stage register contents)
  - the existing op_b_*, alu_op_*, jmp_op_* encodings
- One natural sub-module: disp_src_sel, the per-operand resolution logic, instantiated twice.

## Test plan
- addi x1,x0,5 with all ready: iq_deq at t, rvs_req=0001 at t+1, opc=add, src1 vld=1 data 0, src2 data 5, rat_rd_wr=1 rd=1, stat_disp=1.
- Stream of 4 ALU ops while rvs_rdy[0] is low for 3 cycles: payload held, stat_stall=3, then 4 consecutive issues with no bubbles.
- add x3,x1,x2 with rs1 RAT tag 5 invalid, cdb_valid=1 id 5 data 0xDEAD in the issue cycle: src1_vld=1 data 0xDEAD; rs2 invalid tag 7 → src2_vld=0 tag 7.
- mul with MDU_EN=0: no rvs_req, rob_issue=1 with rob_illegal=1, rat_rd_wr=0.
- Flush while FULL with rvs_rdy=0 and iq_valid=1: no issue or dequeue that cycle, EMPTY next cycle, the following instruction is dequeued the cycle after.
- Store sw x2,8(x1) with rob_rdy=0 for 2 cycles: no req for 2 cycles, then rvs_req=0100, opc[3]=1, offset=8, rat_rd_wr=0.
